simmem_row_delay_estimator: RTL
===============================

Name: simmem_row_delay_estimator

Overview:
- Converts each accepted AXI address request (write or read) into a response-release delay, in cycles, for the simulated memory.
- Tracks one open DRAM row, walks every beat of the burst and accumulates row-hit, precharge and activation costs.
- Sits directly upstream of the write-response and read-data banks, which consume {iid, delay} to schedule releases.

Parameters:
- IidWidth, 5, internal identifier width (max of write_iid_t/read_iid_t widths).
- AddrWidth, AxAddrWidth (16), request address width.
- RowOffsetWidth, RowBufferLenWidth (8), byte-offset bits within a row; row index = addr[AddrWidth-1:RowOffsetWidth].
- DelayWidth, DelayWidth (6), output delay width.
- RowHitCost, 2, cycles per beat to an open row.
- PrechargeCost, 5, cycles to close an open row.
- ActivationCost, 4, cycles to open a row.
- IdleCloseCycles, 16, idle timeout; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request ready
- in_addr_i  in  AddrWidth  start byte address
- in_burst_len_i  in  AxLenWidth (8)  beats minus one
- in_burst_size_i  in  AxSizeWidth (3)  log2 bytes per beat
- in_burst_type_i  in  AxBurstWidth (2)  burst_type_e
- in_iid_i  in  IidWidth  internal identifier
- out_valid_o  out  1  delay result valid
- out_ready_i  in  1  result accepted by the bank
- out_iid_o  out  IidWidth  iid of the result
- out_delay_o  out  DelayWidth  computed delay

Behaviour:
- One clock; reset is asynchronous and active-high; clk_i / rst_i.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, out_iid_o=0, out_delay_o=0, row_open=0, open_row=0, accumulator=0, beat counter=0.
- FSM states IDLE, WALK, OUT.
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, latch addr, len, effective size, type and iid; clear accumulator and beat counter k; go to WALK.
  - WALK: in_ready_o=0. Process beat k each cycle. When k==len, go to OUT.
  - OUT: out_valid_o=1. out_iid_o and out_delay_o are held stable until out_ready_i. On out_valid_o&&out_ready_i, go to IDLE.
- Latency: acceptance on edge E0 makes out_valid_o high after edge E0+len+1. No back-to-back overlap: throughput is one request per len+3 cycles minimum.
- Effective size = min(in_burst_size_i, 2), since MaxBurstSizeBytes=4.
- Beat address, computed modulo 2^AddrWidth:
  - INCR: addr+(k<<size).
  - FIXED and RESERVED: addr.
  - WRAP: window W=(len+1)<<size; base=addr & ~(W-1); beat = base | ((addr+(k<<size)) & (W-1)).
- Per-beat cost, with r = row index of the beat address:
  - row_open && r==open_row: RowHitCost.
  - row_open && r!=open_row: PrechargeCost+ActivationCost+RowHitCost.
  - !row_open: ActivationCost+RowHitCost.
  - After each beat, open_row=r and row_open=1.
- Accumulator is 10 bits wide. out_delay_o = min(acc, 2^DelayWidth-1); it saturates and never wraps.
- Open-row state persists across requests.
- in_valid_i in WALK or OUT is ignored; the upstream source must hold its request.
- Reset in any state returns to IDLE immediately and discards the in-flight result.

Optional Feature:
- Macro SIMMEM_ROW_IDLE_CLOSE_EN.
- When defined: a counter increments every cycle in IDLE with row_open=1 and no acceptance. When it reaches IdleCloseCycles it sets row_open=0, modelling auto-precharge. The next request then pays ActivationCost+RowHitCost on its first beat. The counter clears on acceptance and on reset.
- When undefined: the row stays open indefinitely and no counter logic is present.

Test Plan:
- Reset, then addr 0x0100, len 0, INCR, size 2, iid 3 -> out_delay_o=6, out_iid_o=3, out_valid_o high one cycle after accept.
- Next: addr 0x0104, len 0 -> delay 2 (row hit); then addr 0x0200, len 0 -> delay 11 (row miss).
- Open row 2, then addr 0x01F8, INCR, size 2, len 3 -> beats in rows 1,1,2,2; delay 11+2+11+2=26; out_valid_o 4 cycles after accept.
- FIXED, len 255, at the open row -> accumulator 512, out_delay_o=63 (saturated).
- Hold out_ready_i=0 for 10 cycles in OUT -> outputs stable, in_ready_o=0, a new in_valid_i is not accepted. Assert rst_i mid-WALK -> out_valid_o=0 at once; the next 0x0104, len 0 request gives 6.
- With SIMMEM_ROW_IDLE_CLOSE_EN: request at 0x0100, 16 idle cycles, then 0x0104 -> delay 6. After 15 idle cycles instead -> delay 2.

Source files
------------

// File: rtl/simmem_row_delay_estimator.sv
// Open-row DRAM latency estimator: walks every beat of an AXI burst and turns it into a release delay.
// Optional idle auto-precharge is enabled by defining SIMMEM_ROW_IDLE_CLOSE_EN.
module simmem_row_delay_estimator #(
   parameter int unsigned IidWidth        = 5,
   parameter int unsigned AddrWidth       = 16,
   parameter int unsigned RowOffsetWidth  = 8,
   parameter int unsigned DelayWidth      = 6,
   parameter int unsigned RowHitCost      = 2,
   parameter int unsigned PrechargeCost   = 5,
   parameter int unsigned ActivationCost  = 4,
   parameter int unsigned IdleCloseCycles = 16,
   parameter int unsigned AxLenWidth      = 8,
   parameter int unsigned AxSizeWidth     = 3,
   parameter int unsigned AxBurstWidth    = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [AddrWidth-1:0]    in_addr_i,
   input  logic [AxLenWidth-1:0]   in_burst_len_i,
   input  logic [AxSizeWidth-1:0]  in_burst_size_i,
   input  logic [AxBurstWidth-1:0] in_burst_type_i,
   input  logic [IidWidth-1:0]     in_iid_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [IidWidth-1:0]     out_iid_o,
   output logic [DelayWidth-1:0]   out_delay_o
);

   localparam int unsigned AccWidth = 10;
   localparam int unsigned RowWidth = AddrWidth - RowOffsetWidth;
   localparam logic [AccWidth-1:0]   AccMax   = '1;
   localparam logic [DelayWidth-1:0] DelayMax = '1;

   typedef enum logic [1:0] {
      BURST_FIXED    = 2'd0,
      BURST_INCR     = 2'd1,
      BURST_WRAP     = 2'd2,
      BURST_RESERVED = 2'd3
   } burst_type_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_OUT
   } state_e;

   // The idle-close timeout only matters with the optional feature, but must never be zero.
   if (IdleCloseCycles == 0) begin : g_idle_close_cycles_invalid
   end

   state_e                  r_state;
   state_e                  w_state_next;
   logic [AddrWidth-1:0]    r_addr;
   logic [AxLenWidth-1:0]   r_len;
   logic [1:0]              r_size;
   burst_type_e             r_type;
   logic [IidWidth-1:0]     r_iid;
   logic [AxLenWidth-1:0]   r_k;
   logic [AccWidth-1:0]     r_acc;
   logic                    r_row_open;
   logic [RowWidth-1:0]     r_open_row;
   logic [IidWidth-1:0]     r_out_iid;
   logic [DelayWidth-1:0]   r_out_delay;

   logic                    w_accept;
   logic                    w_last_beat;
   logic [1:0]              w_size_eff;
   logic [AddrWidth-1:0]    w_step;
   logic [AddrWidth-1:0]    w_incr_addr;
   logic [AddrWidth-1:0]    w_wrap_win;
   logic [AddrWidth-1:0]    w_wrap_mask;
   logic [AddrWidth-1:0]    w_beat_addr;
   logic [RowWidth-1:0]     w_beat_row;
   logic [AccWidth-1:0]     w_cost;
   logic [AccWidth:0]       w_acc_sum;
   logic [AccWidth-1:0]     w_acc_next;
   logic [DelayWidth-1:0]   w_delay_sat;

   assign w_accept    = in_valid_i && in_ready_o;
   assign w_last_beat = (r_k == r_len);
   // Beats never exceed 4 bytes in the simulated memory.
   assign w_size_eff  = (in_burst_size_i > AxSizeWidth'(2)) ? 2'd2 : in_burst_size_i[1:0];

   // Beat address generation, all arithmetic modulo 2^AddrWidth.
   assign w_step      = AddrWidth'(r_k) << r_size;
   assign w_incr_addr = r_addr + w_step;
   assign w_wrap_win  = (AddrWidth'(r_len) + AddrWidth'(1)) << r_size;
   assign w_wrap_mask = w_wrap_win - AddrWidth'(1);

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no latch is inferred.
      w_beat_addr = r_addr;
      case (r_type)
         BURST_INCR: w_beat_addr = w_incr_addr;
         BURST_WRAP: w_beat_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
         default:    w_beat_addr = r_addr;
      endcase
   end

   assign w_beat_row = w_beat_addr[AddrWidth-1:RowOffsetWidth];

   always_comb begin
      w_cost = AccWidth'(ActivationCost + RowHitCost);
      if (r_row_open) begin
         if (w_beat_row == r_open_row) begin
            w_cost = AccWidth'(RowHitCost);
         end else begin
            w_cost = AccWidth'(PrechargeCost + ActivationCost + RowHitCost);
         end
      end
   end

   // The accumulator itself saturates, so the reported delay can never wrap back down.
   assign w_acc_sum   = {1'b0, r_acc} + {1'b0, w_cost};
   assign w_acc_next  = w_acc_sum[AccWidth] ? AccMax : w_acc_sum[AccWidth-1:0];
   assign w_delay_sat = (w_acc_next > AccWidth'(DelayMax)) ? DelayMax : w_acc_next[DelayWidth-1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (w_accept) w_state_next = ST_WALK;
         end
         ST_WALK: begin
            if (w_last_beat) w_state_next = ST_OUT;
         end
         ST_OUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

`ifdef SIMMEM_ROW_IDLE_CLOSE_EN
   localparam int unsigned IdleCntWidth = $clog2(IdleCloseCycles + 1);
   logic [IdleCntWidth-1:0] r_idle_cnt;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr      <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_type      <= BURST_FIXED;
         r_iid       <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_row_open  <= 1'b0;
         r_open_row  <= '0;
         r_out_iid   <= '0;
         r_out_delay <= '0;
`ifdef SIMMEM_ROW_IDLE_CLOSE_EN
         r_idle_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr <= in_addr_i;
                  r_len  <= in_burst_len_i;
                  r_size <= w_size_eff;
                  r_type <= burst_type_e'(in_burst_type_i);
                  r_iid  <= in_iid_i;
                  r_acc  <= '0;
                  r_k    <= '0;
               end
`ifdef SIMMEM_ROW_IDLE_CLOSE_EN
               // Auto-precharge after a run of idle cycles with the row left open.
               if (w_accept) begin
                  r_idle_cnt <= '0;
               end else if (r_row_open) begin
                  if (r_idle_cnt == IdleCntWidth'(IdleCloseCycles - 1)) begin
                     r_row_open <= 1'b0;
                     r_idle_cnt <= '0;
                  end else begin
                     r_idle_cnt <= r_idle_cnt + IdleCntWidth'(1);
                  end
               end
`endif
            end
            ST_WALK: begin
               r_acc      <= w_acc_next;
               r_k        <= r_k + AxLenWidth'(1);
               r_open_row <= w_beat_row;
               r_row_open <= 1'b1;
               if (w_last_beat) begin
                  r_out_iid   <= r_iid;
                  r_out_delay <= w_delay_sat;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_iid_o   = r_out_iid;
   assign out_delay_o = r_out_delay;

endmodule
